// File: rtl/pe_pkg.sv
// Shared encodings, width helpers and default parameters for the multi-lane PE.
package pe_pkg;

    localparam logic [1:0] PE_TYPE_A    = 2'd0;
    localparam logic [1:0] PE_TYPE_C    = 2'd1;
    localparam logic [1:0] PE_TYPE_ZERO = 2'd2;
    localparam logic [1:0] PE_TYPE_RSVD = 2'd3;

    localparam int unsigned PE_DEF_X        = 0;
    localparam int unsigned PE_DEF_Y        = 0;
    localparam int unsigned PE_DEF_SARRAY_W = 8;
    localparam int unsigned PE_DEF_SARRAY_H = 8;
    localparam int unsigned PE_DEF_DW       = 8;
    localparam int unsigned PE_DEF_LANES    = 4;
    localparam int unsigned PE_DEF_ACC_W    = 32;
    localparam int unsigned PE_DEF_BANKS    = 2;
    localparam int unsigned PE_DEF_CNT_W    = 4;

    function automatic int unsigned pe_bus_w(input int unsigned lanes, input int unsigned dw);
        return lanes * dw;
    endfunction

    // A single bank still needs a one-bit select port.
    function automatic int unsigned pe_bank_w(input int unsigned banks);
        return (banks > 1) ? $clog2(banks) : 1;
    endfunction

endpackage

// File: rtl/pe_mlane_dot.sv
// Combinational LANES x DW dot product; lanes sign- or zero-extended by sign.
module pe_mlane_dot
    import pe_pkg::*;
#(
    parameter int unsigned DW    = PE_DEF_DW,
    parameter int unsigned LANES = PE_DEF_LANES,
    parameter int unsigned ACC_W = PE_DEF_ACC_W
) (
    input  logic [LANES*DW-1:0] a,
    input  logic [LANES*DW-1:0] b,
    input  logic                sign,
    output logic [ACC_W-1:0]    dot_c
);

    logic [ACC_W-1:0] prod [LANES];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [DW:0]     ea;
        logic signed [DW:0]     eb;
        logic signed [2*DW+1:0] p;

        // One extra bit per lane lets a single signed multiplier serve both modes.
        assign ea      = {sign & a[i*DW+DW-1], a[i*DW +: DW]};
        assign eb      = {sign & b[i*DW+DW-1], b[i*DW +: DW]};
        assign p       = ea * eb;
        assign prod[i] = ACC_W'(p);
    end

    always_comb begin
        dot_c = '0;
        for (int i = 0; i < LANES; i++) begin
            dot_c = dot_c + prod[i];
        end
    end

endmodule

// File: rtl/pe_mlane.sv
// Systolic PE: banked multi-lane MAC, C preload/clear, store tokens and a lossless result chain.
module pe_mlane
    import pe_pkg::*;
#(
    parameter int unsigned X        = PE_DEF_X,
    parameter int unsigned Y        = PE_DEF_Y,
    parameter int unsigned SARRAY_W = PE_DEF_SARRAY_W,
    parameter int unsigned SARRAY_H = PE_DEF_SARRAY_H,
    parameter int unsigned DW       = PE_DEF_DW,
    parameter int unsigned LANES    = PE_DEF_LANES,
    parameter int unsigned ACC_W    = PE_DEF_ACC_W,
    parameter int unsigned BANKS    = PE_DEF_BANKS,
    parameter int unsigned CNT_W    = PE_DEF_CNT_W,
    localparam int unsigned BUS_W   = pe_bus_w(LANES, DW),
    localparam int unsigned BANK_W  = pe_bank_w(BANKS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              top_valid_i,
    input  logic [CNT_W-1:0]  top_cnt_i,
    input  logic [BUS_W-1:0]  top_data_i,
    input  logic              top_storec_valid_i,
    input  logic [BANK_W-1:0] top_storec_bank_i,
    input  logic              top_d_valid_i,
    input  logic [CNT_W-1:0]  top_d_cnt_i,
    input  logic [ACC_W-1:0]  top_d_data_i,
    input  logic              left_valid_i,
    input  logic [CNT_W-1:0]  left_cnt_i,
    input  logic [1:0]        left_type_i,
    input  logic              left_sign_i,
    input  logic [BANK_W-1:0] left_bank_i,
    input  logic [BUS_W-1:0]  left_data_i,
    output logic              bot_valid_o,
    output logic [CNT_W-1:0]  bot_cnt_o,
    output logic [BUS_W-1:0]  bot_data_o,
    output logic              bot_storec_valid_o,
    output logic [BANK_W-1:0] bot_storec_bank_o,
    output logic              bot_d_valid_o,
    output logic [CNT_W-1:0]  bot_d_cnt_o,
    output logic [ACC_W-1:0]  bot_d_data_o,
    output logic              right_valid_o,
    output logic [CNT_W-1:0]  right_cnt_o,
    output logic [1:0]        right_type_o,
    output logic              right_sign_o,
    output logic [BANK_W-1:0] right_bank_o,
    output logic [BUS_W-1:0]  right_data_o,
    output logic              err_o
);

    localparam int unsigned HIT_CNT = SARRAY_W - X;
    localparam int unsigned OWN_CNT = SARRAY_H - Y;
    localparam int unsigned GAP_MIN = SARRAY_H + 1;
    localparam int unsigned GAP_W   = $clog2(GAP_MIN + 1);

    logic [ACC_W-1:0] acc_q [BANKS];
    logic [ACC_W-1:0] hold_q, hold_d;
    logic             hold_v_q, hold_v_d;
    logic [GAP_W-1:0] gap_q;
    logic [ACC_W-1:0] dot_c;

    logic             is_a, fire, cnt_hit, c_hit, zero_hit, fwd_right, proto_err;
    logic [ACC_W-1:0] tok_val;
    logic             d_valid_d;
    logic [CNT_W-1:0] d_cnt_d;
    logic [ACC_W-1:0] d_data_d;

    pe_mlane_dot #(.DW(DW), .LANES(LANES), .ACC_W(ACC_W)) u_dot (
        .a     (left_data_i),
        .b     (top_data_i),
        .sign  (left_sign_i),
        .dot_c (dot_c)
    );

    // Decode of the left channel, store token and protocol checks.
    always_comb begin
        is_a      = left_valid_i && (left_type_i == PE_TYPE_A);
        fire      = is_a && top_valid_i;
        cnt_hit   = (left_cnt_i == CNT_W'(HIT_CNT));
        c_hit     = left_valid_i && (left_type_i == PE_TYPE_C) && cnt_hit;
        zero_hit  = left_valid_i && (left_type_i == PE_TYPE_ZERO) && cnt_hit;
        fwd_right = fire || (left_valid_i && !is_a && !c_hit);
        tok_val   = acc_q[top_storec_bank_i];
        proto_err = (is_a != top_valid_i) ||
                    (top_storec_valid_i && (hold_v_q || (gap_q < GAP_W'(GAP_MIN))));
    end

    // Result chain: upstream first, then parked result, else own result bypasses the hold.
    always_comb begin
        hold_d    = hold_q;
        hold_v_d  = hold_v_q;
        d_valid_d = 1'b0;
        d_cnt_d   = bot_d_cnt_o;
        d_data_d  = bot_d_data_o;
        if (top_d_valid_i) begin
            d_valid_d = 1'b1;
            d_cnt_d   = top_d_cnt_i;
            d_data_d  = top_d_data_i;
        end else if (hold_v_q) begin
            d_valid_d = 1'b1;
            d_cnt_d   = CNT_W'(OWN_CNT);
            d_data_d  = hold_q;
            hold_v_d  = 1'b0;
        end else if (top_storec_valid_i) begin
            d_valid_d = 1'b1;
            d_cnt_d   = CNT_W'(OWN_CNT);
            d_data_d  = tok_val;
        end
        if (top_storec_valid_i && (top_d_valid_i || hold_v_q)) begin
            hold_d   = tok_val;
            hold_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BANKS; i++) begin
                acc_q[i] <= '0;
            end
        end else if (fire) begin
            acc_q[left_bank_i] <= acc_q[left_bank_i] + dot_c;
        end else if (c_hit) begin
            acc_q[left_bank_i] <= left_data_i[ACC_W-1:0];
        end else if (zero_hit) begin
            acc_q[left_bank_i] <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q        <= '0;
            hold_v_q      <= 1'b0;
            gap_q         <= GAP_W'(GAP_MIN);
            err_o         <= 1'b0;
            bot_d_valid_o <= 1'b0;
            bot_d_cnt_o   <= '0;
            bot_d_data_o  <= '0;
        end else begin
            hold_q        <= hold_d;
            hold_v_q      <= hold_v_d;
            err_o         <= err_o | proto_err;
            bot_d_valid_o <= d_valid_d;
            bot_d_cnt_o   <= d_cnt_d;
            bot_d_data_o  <= d_data_d;
            if (top_storec_valid_i) begin
                gap_q <= GAP_W'(1);
            end else if (gap_q < GAP_W'(GAP_MIN)) begin
                gap_q <= gap_q + GAP_W'(1);
            end
        end
    end

    // Single-stage forward registers toward right and bottom neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            right_valid_o      <= 1'b0;
            right_cnt_o        <= '0;
            right_type_o       <= '0;
            right_sign_o       <= 1'b0;
            right_bank_o       <= '0;
            right_data_o       <= '0;
            bot_valid_o        <= 1'b0;
            bot_cnt_o          <= '0;
            bot_data_o         <= '0;
            bot_storec_valid_o <= 1'b0;
            bot_storec_bank_o  <= '0;
        end else begin
            right_valid_o      <= fwd_right;
            bot_valid_o        <= fire;
            bot_storec_valid_o <= top_storec_valid_i;
            bot_storec_bank_o  <= top_storec_bank_i;
            if (fwd_right) begin
                right_cnt_o  <= left_cnt_i;
                right_type_o <= left_type_i;
                right_sign_o <= left_sign_i;
                right_bank_o <= left_bank_i;
                right_data_o <= left_data_i;
            end
            if (fire) begin
                bot_cnt_o  <= top_cnt_i;
                bot_data_o <= top_data_i;
            end
        end
    end

endmodule

// File: tb/tb_pe_mlane.sv
// Scoreboard bench for pe_mlane: directed stimulus pushes expectations, a monitor pops and compares.
module tb_pe_mlane;
    import pe_pkg::*;

    localparam int unsigned X = 2, Y = 1, SW = 4, SH = 4;
    localparam int unsigned DW = 8, LANES = 4, ACC_W = 32, BANKS = 2, CNT_W = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        top_valid_i, top_storec_valid_i, top_d_valid_i, left_valid_i, left_sign_i;
    logic [3:0]  top_cnt_i, top_d_cnt_i, left_cnt_i;
    logic [31:0] top_data_i, top_d_data_i, left_data_i;
    logic [0:0]  top_storec_bank_i, left_bank_i;
    logic [1:0]  left_type_i;
    logic        bot_valid_o, bot_storec_valid_o, bot_d_valid_o, right_valid_o, right_sign_o, err_o;
    logic [3:0]  bot_cnt_o, bot_d_cnt_o, right_cnt_o;
    logic [31:0] bot_data_o, bot_d_data_o, right_data_o;
    logic [0:0]  bot_storec_bank_o, right_bank_o;
    logic [1:0]  right_type_o;

    always #5 clk = ~clk;

    pe_mlane #(.X(X), .Y(Y), .SARRAY_W(SW), .SARRAY_H(SH), .DW(DW), .LANES(LANES),
               .ACC_W(ACC_W), .BANKS(BANKS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .top_valid_i(top_valid_i), .top_cnt_i(top_cnt_i), .top_data_i(top_data_i),
        .top_storec_valid_i(top_storec_valid_i), .top_storec_bank_i(top_storec_bank_i),
        .top_d_valid_i(top_d_valid_i), .top_d_cnt_i(top_d_cnt_i), .top_d_data_i(top_d_data_i),
        .left_valid_i(left_valid_i), .left_cnt_i(left_cnt_i), .left_type_i(left_type_i),
        .left_sign_i(left_sign_i), .left_bank_i(left_bank_i), .left_data_i(left_data_i),
        .bot_valid_o(bot_valid_o), .bot_cnt_o(bot_cnt_o), .bot_data_o(bot_data_o),
        .bot_storec_valid_o(bot_storec_valid_o), .bot_storec_bank_o(bot_storec_bank_o),
        .bot_d_valid_o(bot_d_valid_o), .bot_d_cnt_o(bot_d_cnt_o), .bot_d_data_o(bot_d_data_o),
        .right_valid_o(right_valid_o), .right_cnt_o(right_cnt_o), .right_type_o(right_type_o),
        .right_sign_o(right_sign_o), .right_bank_o(right_bank_o), .right_data_o(right_data_o),
        .err_o(err_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [39:0] q_right [$];
    logic [35:0] q_bot   [$];
    logic [35:0] q_d     [$];
    logic [0:0]  q_tok   [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected output %h, nothing expected", name, act);
    endtask

    // Monitor: every valid output must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (right_valid_o) begin
                if (q_right.size() == 0)
                    unexpected("right", 64'({right_cnt_o, right_type_o, right_sign_o, right_bank_o, right_data_o}));
                else
                    check("right", 64'({right_cnt_o, right_type_o, right_sign_o, right_bank_o, right_data_o}),
                          64'(q_right.pop_front()));
            end
            if (bot_valid_o) begin
                if (q_bot.size() == 0) unexpected("bot", 64'({bot_cnt_o, bot_data_o}));
                else check("bot", 64'({bot_cnt_o, bot_data_o}), 64'(q_bot.pop_front()));
            end
            if (bot_d_valid_o) begin
                if (q_d.size() == 0) unexpected("bot_d", 64'({bot_d_cnt_o, bot_d_data_o}));
                else check("bot_d", 64'({bot_d_cnt_o, bot_d_data_o}), 64'(q_d.pop_front()));
            end
            if (bot_storec_valid_o) begin
                if (q_tok.size() == 0) unexpected("bot_storec", 64'(bot_storec_bank_o));
                else check("bot_storec", 64'(bot_storec_bank_o), 64'(q_tok.pop_front()));
            end
        end
    end

    task automatic clear_inputs();
        top_valid_i = 0; top_cnt_i = 0; top_data_i = 0;
        top_storec_valid_i = 0; top_storec_bank_i = 0;
        top_d_valid_i = 0; top_d_cnt_i = 0; top_d_data_i = 0;
        left_valid_i = 0; left_cnt_i = 0; left_type_i = 0;
        left_sign_i = 0; left_bank_i = 0; left_data_i = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        clear_inputs();
        repeat (n) step();
    endtask

    task automatic do_left(input logic [1:0] typ, input logic [3:0] cnt, input logic sg,
                           input logic bk, input logic [31:0] d, input logic exp_fwd);
        clear_inputs();
        left_valid_i = 1; left_type_i = typ; left_cnt_i = cnt;
        left_sign_i = sg; left_bank_i = bk; left_data_i = d;
        if (exp_fwd) q_right.push_back({cnt, typ, sg, bk, d});
        step();
        clear_inputs();
    endtask

    task automatic do_mac(input logic [31:0] a, input logic [31:0] b, input logic sg, input logic bk);
        clear_inputs();
        left_valid_i = 1; left_type_i = PE_TYPE_A; left_cnt_i = 4'd3;
        left_sign_i = sg; left_bank_i = bk; left_data_i = a;
        top_valid_i = 1; top_cnt_i = 4'd2; top_data_i = b;
        q_right.push_back({4'd3, PE_TYPE_A, sg, bk, a});
        q_bot.push_back({4'd2, b});
        step();
        clear_inputs();
    endtask

    task automatic do_token(input logic bk, input logic [31:0] exp_val);
        clear_inputs();
        top_storec_valid_i = 1; top_storec_bank_i = bk;
        q_tok.push_back(bk);
        q_d.push_back({4'd3, exp_val});
        step();
        clear_inputs();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_right"}, 64'({right_valid_o, right_cnt_o, right_type_o, right_sign_o, right_bank_o, right_data_o}), 64'd0);
        check({tag, "_bot"}, 64'({bot_valid_o, bot_cnt_o, bot_data_o}), 64'd0);
        check({tag, "_bot_d"}, 64'({bot_d_valid_o, bot_d_cnt_o, bot_d_data_o}), 64'd0);
        check({tag, "_storec"}, 64'({bot_storec_valid_o, bot_storec_bank_o}), 64'd0);
        check({tag, "_err"}, 64'(err_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        #2 rst_n = 0;
        #1 check_outputs_zero("reset_initial");
        step(); step();
        rst_n = 1;
        idle(2);

        // C preload then one MAC and a store: 100 + 70.
        do_left(PE_TYPE_C, 4'd2, 1'b0, 1'b1, 32'd100, 1'b0);
        do_mac(32'h04030201, 32'h08070605, 1'b1, 1'b1);
        idle(6);
        do_token(1'b1, 32'd170);
        idle(6);

        // Pass-through: C miss and RSVD leave acc untouched.
        do_left(PE_TYPE_C, 4'd1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1);
        do_left(PE_TYPE_RSVD, 4'd2, 1'b0, 1'b0, 32'h12345678, 1'b1);
        idle(6);
        do_token(1'b1, 32'd170);
        idle(6);

        // Signedness: 4 x (0xFF * 2).
        do_left(PE_TYPE_ZERO, 4'd2, 1'b0, 1'b0, 32'd0, 1'b1);
        do_mac(32'hFFFFFFFF, 32'h02020202, 1'b1, 1'b0);
        idle(6);
        do_token(1'b0, 32'hFFFFFFF8);
        idle(2);
        do_left(PE_TYPE_ZERO, 4'd2, 1'b0, 1'b0, 32'd0, 1'b1);
        do_mac(32'hFFFFFFFF, 32'h02020202, 1'b0, 1'b0);
        idle(6);
        do_token(1'b0, 32'd2040);
        idle(6);

        // ZERO hit clears bank0.
        do_left(PE_TYPE_ZERO, 4'd2, 1'b1, 1'b0, 32'hCAFE0000, 1'b1);
        idle(6);
        do_token(1'b0, 32'd0);
        idle(6);

        // Chain merge: upstream words keep priority, own result follows.
        clear_inputs();
        top_storec_valid_i = 1; top_storec_bank_i = 1'b1;
        top_d_valid_i = 1; top_d_cnt_i = 4'd4; top_d_data_i = 32'd11;
        q_tok.push_back(1'b1);
        q_d.push_back({4'd4, 32'd11});
        step();
        clear_inputs();
        top_d_valid_i = 1; top_d_cnt_i = 4'd4; top_d_data_i = 32'd22;
        q_d.push_back({4'd4, 32'd22});
        q_d.push_back({4'd3, 32'd170});
        step();
        idle(6);
        check("err_clean_before_overwrite", 64'(err_o), 64'd0);

        // Second token while a result is parked: error, hold overwritten with bank0 (0).
        clear_inputs();
        top_storec_valid_i = 1; top_storec_bank_i = 1'b1;
        top_d_valid_i = 1; top_d_cnt_i = 4'd4; top_d_data_i = 32'd33;
        q_tok.push_back(1'b1);
        q_d.push_back({4'd4, 32'd33});
        step();
        clear_inputs();
        top_storec_valid_i = 1; top_storec_bank_i = 1'b0;
        top_d_valid_i = 1; top_d_cnt_i = 4'd4; top_d_data_i = 32'd44;
        q_tok.push_back(1'b0);
        q_d.push_back({4'd4, 32'd44});
        q_d.push_back({4'd3, 32'd0});
        step();
        check("err_hold_overwrite", 64'(err_o), 64'd1);
        idle(4);
        check("err_sticky", 64'(err_o), 64'd1);
        check("drain_before_reset", 64'(q_right.size() + q_bot.size() + q_d.size() + q_tok.size()), 64'd0);

        // Reset mid-traffic: in-flight words are dropped.
        clear_inputs();
        left_valid_i = 1; left_type_i = PE_TYPE_A; left_bank_i = 1'b1; left_data_i = 32'h01010101;
        top_valid_i = 1; top_data_i = 32'h01010101;
        top_storec_valid_i = 1; top_storec_bank_i = 1'b1;
        top_d_valid_i = 1; top_d_cnt_i = 4'd4; top_d_data_i = 32'd55;
        step();
        rst_n = 0;
        #1 check_outputs_zero("reset_mid");
        clear_inputs();
        step(); step();
        rst_n = 1;
        idle(2);

        // Accumulators and hold are cleared by reset.
        do_token(1'b1, 32'd0);
        idle(2);
        check("err_after_reset", 64'(err_o), 64'd0);

        // A without B: error, nothing forwarded.
        idle(4);
        do_left(PE_TYPE_A, 4'd3, 1'b0, 1'b0, 32'h0A0A0A0A, 1'b0);
        check("err_a_without_b", 64'(err_o), 64'd1);
        idle(3);
        check("final_drain", 64'(q_right.size() + q_bot.size() + q_d.size() + q_tok.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
